// File: rtl/code2421_pkg.sv
// Shared types and constants for the 2421 receive checker: FSM states, the ten
// legal 2421 code words and the digit successor helper.
package code2421_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_t;

    localparam logic [3:0] CODE_0 = 4'b0000;
    localparam logic [3:0] CODE_1 = 4'b0001;
    localparam logic [3:0] CODE_2 = 4'b0010;
    localparam logic [3:0] CODE_3 = 4'b0011;
    localparam logic [3:0] CODE_4 = 4'b0100;
    localparam logic [3:0] CODE_5 = 4'b1011;
    localparam logic [3:0] CODE_6 = 4'b1100;
    localparam logic [3:0] CODE_7 = 4'b1101;
    localparam logic [3:0] CODE_8 = 4'b1110;
    localparam logic [3:0] CODE_9 = 4'b1111;

    localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

    // Decimal successor, wrapping 9 back to 0.
    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/code2421_dec.sv
// Combinational 2421 to 8421 BCD decoder; illegal words give DIGIT_ILLEGAL with
// legal low.
module code2421_dec
    import code2421_pkg::*;
(
    input  logic [3:0] code,
    output logic       legal,
    output logic [3:0] digit
);

    always_comb begin
        legal = 1'b1;
        digit = DIGIT_ILLEGAL;
        case (code)
            CODE_0:  digit = 4'd0;
            CODE_1:  digit = 4'd1;
            CODE_2:  digit = 4'd2;
            CODE_3:  digit = 4'd3;
            CODE_4:  digit = 4'd4;
            CODE_5:  digit = 4'd5;
            CODE_6:  digit = 4'd6;
            CODE_7:  digit = 4'd7;
            CODE_8:  digit = 4'd8;
            CODE_9:  digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/code2421_rx_checker.sv
// Receive-side 2421 checker: decodes each accepted word, tracks count sequence
// with a HUNT/SYNC/LOCKED FSM and keeps a saturating error count while locked.
module code2421_rx_checker
    import code2421_pkg::*;
#(
    parameter int unsigned LOCK_LEN  = 3,
    parameter int unsigned MISS_MAX  = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [3:0]           in_code,
    output logic                 out_valid,
    output logic [3:0]           out_digit,
    output logic                 err_code,
    output logic                 err_seq,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CNT_W  = $clog2(LOCK_LEN + 1);
    localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

    state_t               state_q, state_d;
    logic [3:0]           prev_q, prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           out_digit_q, out_digit_d;
    logic                 err_code_q, err_code_d;
    logic                 err_seq_q, err_seq_d;

    logic       dec_legal;
    logic [3:0] dec_digit;
    logic       is_succ;
    logic       flag_err;

    code2421_dec u_dec (
        .code  (in_code),
        .legal (dec_legal),
        .digit (dec_digit)
    );

    assign is_succ = dec_legal && (dec_digit == next_digit(prev_q));

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        out_valid_d = 1'b0;
        out_digit_d = out_digit_q;
        err_code_d  = 1'b0;
        err_seq_d   = 1'b0;
        flag_err    = 1'b0;

        if (clear) begin
            state_d   = HUNT;
            cnt_d     = '0;
            miss_d    = '0;
            err_cnt_d = '0;
        end else if (in_valid) begin
            out_valid_d = 1'b1;
            out_digit_d = dec_digit;
            unique case (state_q)
                HUNT: begin
                    if (dec_legal) begin
                        prev_d  = dec_digit;
                        cnt_d   = CNT_W'(1);
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (!dec_legal) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else if (is_succ) begin
                        prev_d = dec_digit;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(LOCK_LEN)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        prev_d = dec_digit;
                        cnt_d  = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (is_succ) begin
                        prev_d = dec_digit;
                        miss_d = '0;
                    end else begin
                        flag_err = 1'b1;
                        // A legal but out-of-order word resyncs prev to it.
                        if (dec_legal) begin
                            err_seq_d = 1'b1;
                            prev_d    = dec_digit;
                        end else begin
                            err_code_d = 1'b1;
                        end
                        miss_d = miss_q + MISS_W'(1);
                        if (miss_q + MISS_W'(1) == MISS_W'(MISS_MAX)) begin
                            state_d = HUNT;
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (flag_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            cnt_q       <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            err_code_q  <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            err_code_q  <= err_code_d;
            err_seq_q   <= err_seq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign err_code  = err_code_q;
    assign err_seq   = err_seq_q;
    assign locked    = (state_q == LOCKED);
    assign err_count = err_cnt_q;

endmodule
